// File: rtl/oric_ram_arbiter.sv
// Arbiter for port 1 of the Oric main RAM: clear engine, CPU/ULA bus and buffered tape-loader writes.
// All RAM strobes are registered; CPU read data returns two cycles after the request is sampled.
module oric_ram_arbiter #(
  parameter logic [7:0] FILL   = 8'hFF,
  parameter int         FDEPTH = 4
) (
  input  logic        clk_48,
  input  logic        reset,
  input  logic        cpu_cs,
  input  logic        cpu_we,
  input  logic [15:0] cpu_ad,
  input  logic [7:0]  cpu_d,
  output logic [7:0]  cpu_q,
  input  logic        tape_wr,
  input  logic [15:0] tape_addr,
  input  logic [7:0]  tape_dout,
  input  logic        tape_done_in,
  output logic        tape_done_out,
  output logic        tape_full,
  output logic        tape_ovf,
  output logic        clr_busy,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_di,
  input  logic [7:0]  mem_do
);

  localparam int AW = $clog2(FDEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FDEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [15:0]   clr_cnt;
  logic [15:0]   fifo_a [FDEPTH];
  logic [7:0]    fifo_d [FDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;

  logic        rep_valid, rep_we;
  logic [15:0] rep_ad;
  logic [7:0]  rep_d;
  logic        rd_s1, rd_s2;

  logic fifo_empty, fifo_full, is_repeat;
  logic gnt_cpu, gnt_tape, gnt_rep, push, pop;

  // A held CPU request is idempotent, so its repeat slots are lent to the tape FIFO.
  always_comb begin
    fifo_empty = (count == '0);
    fifo_full  = (count == FULL_CNT);
    is_repeat  = rep_valid && ({cpu_we, cpu_ad, cpu_d} == {rep_we, rep_ad, rep_d});
    gnt_cpu    = !clr_busy && cpu_cs && !is_repeat;
    gnt_tape   = !clr_busy && !gnt_cpu && !fifo_empty;
    gnt_rep    = !clr_busy && cpu_cs && is_repeat && fifo_empty;
    pop        = gnt_tape;
    push       = tape_wr && (!fifo_full || pop);
    count_nxt  = count;
    if (push && !pop)
      count_nxt = count + CNT_ONE;
    else if (!push && pop)
      count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk_48) begin
    if (reset) begin
      mem_ce   <= 1'b0;
      mem_we   <= 1'b0;
      mem_a    <= 16'h0000;
      mem_di   <= 8'h00;
      clr_busy <= 1'b1;
      clr_cnt  <= 16'h0000;
    end else begin
      mem_ce <= 1'b0;
      mem_we <= 1'b0;
      if (clr_busy) begin
        mem_ce  <= 1'b1;
        mem_we  <= 1'b1;
        mem_a   <= clr_cnt;
        mem_di  <= FILL;
        clr_cnt <= clr_cnt + 16'd1;
        if (clr_cnt == 16'hFFFF)
          clr_busy <= 1'b0;
      end else if (gnt_cpu || gnt_rep) begin
        mem_ce <= 1'b1;
        mem_we <= cpu_we;
        mem_a  <= cpu_ad;
        mem_di <= cpu_d;
      end else if (gnt_tape) begin
        mem_ce <= 1'b1;
        mem_we <= 1'b1;
        mem_a  <= fifo_a[rd_ptr];
        mem_di <= fifo_d[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk_48) begin
    if (push) begin
      fifo_a[wr_ptr] <= tape_addr;
      fifo_d[wr_ptr] <= tape_dout;
    end
  end

  always_ff @(posedge clk_48) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      tape_full     <= 1'b0;
      tape_ovf      <= 1'b0;
      tape_done_out <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      count         <= count_nxt;
      tape_full     <= (count_nxt == FULL_CNT);
      tape_done_out <= tape_done_in && fifo_empty && !gnt_tape;
      if (tape_wr && !push)
        tape_ovf <= 1'b1;
    end
  end

  // A tape write landing on the tracked address makes the next CPU cycle a fresh request.
  always_ff @(posedge clk_48) begin
    if (reset) begin
      rep_valid <= 1'b0;
      rep_we    <= 1'b0;
      rep_ad    <= 16'h0000;
      rep_d     <= 8'h00;
      rd_s1     <= 1'b0;
      rd_s2     <= 1'b0;
      cpu_q     <= FILL;
    end else begin
      if (gnt_cpu) begin
        rep_valid <= 1'b1;
        rep_we    <= cpu_we;
        rep_ad    <= cpu_ad;
        rep_d     <= cpu_d;
      end else if (gnt_tape && fifo_a[rd_ptr] == rep_ad) begin
        rep_valid <= 1'b0;
      end
      rd_s1 <= (gnt_cpu || gnt_rep) && !cpu_we;
      rd_s2 <= rd_s1;
      if (rd_s2)
        cpu_q <= mem_do;
    end
  end

endmodule

// File: tb/tb_oric_ram_arbiter.sv
// Scoreboard bench for oric_ram_arbiter: expected RAM transactions are queued at stimulus time
// and popped by a monitor whenever the arbiter drives mem_ce.
module tb_oric_ram_arbiter;

  localparam logic [7:0] FILL = 8'hFF;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } txn_t;

  logic        clk_48 = 1'b0;
  logic        reset;
  logic        cpu_cs, cpu_we;
  logic [15:0] cpu_ad;
  logic [7:0]  cpu_d;
  logic [7:0]  cpu_q;
  logic        tape_wr;
  logic [15:0] tape_addr;
  logic [7:0]  tape_dout;
  logic        tape_done_in, tape_done_out, tape_full, tape_ovf, clr_busy;
  logic        mem_ce, mem_we;
  logic [15:0] mem_a;
  logic [7:0]  mem_di;
  logic [7:0]  mem_do = 8'h00;

  logic [7:0] ram [65536];
  txn_t       exp_q [$];
  int         checks = 0;
  int         failures = 0;

  oric_ram_arbiter #(.FILL(FILL), .FDEPTH(4)) dut (
    .clk_48(clk_48), .reset(reset),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_ad(cpu_ad), .cpu_d(cpu_d), .cpu_q(cpu_q),
    .tape_wr(tape_wr), .tape_addr(tape_addr), .tape_dout(tape_dout),
    .tape_done_in(tape_done_in), .tape_done_out(tape_done_out),
    .tape_full(tape_full), .tape_ovf(tape_ovf), .clr_busy(clr_busy),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_a(mem_a), .mem_di(mem_di), .mem_do(mem_do)
  );

  always #5 clk_48 = ~clk_48;

  // Behavioural single-port RAM with one cycle of read latency.
  always @(posedge clk_48) begin
    if (mem_ce) begin
      if (mem_we)
        ram[mem_a] <= mem_di;
      else
        mem_do <= ram[mem_a];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input logic cs, input logic we, input logic [15:0] ad,
                               input logic [7:0] d, input logic twr,
                               input logic [15:0] ta, input logic [7:0] td);
    cpu_cs    = cs;
    cpu_we    = we;
    cpu_ad    = ad;
    cpu_d     = d;
    tape_wr   = twr;
    tape_addr = ta;
    tape_dout = td;
  endtask

  task automatic pushExp(input logic we, input logic [15:0] addr, input logic [7:0] data);
    txn_t t;
    t.we   = we;
    t.addr = addr;
    t.data = data;
    exp_q.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk_48);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00);
  endtask

  // Monitor: read data is irrelevant on mem_di, so only writes compare it.
  always @(negedge clk_48) begin
    if (!reset && mem_ce) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL mem_unexpected: got we=%0b a=%h di=%h expected no access", mem_we, mem_a, mem_di);
      end else begin
        txn_t e;
        e = exp_q.pop_front();
        checkOutput("mem_txn", {7'd0, mem_we, mem_a, (mem_we ? mem_di : 8'h00)},
                    {7'd0, e.we, e.addr, (e.we ? e.data : 8'h00)});
      end
    end
  end

  // Edges 1..8 of a sweep: five back-to-back tape writes sampled at edges 3..7 against a 4-deep FIFO.
  task automatic overflowPhase(input logic [15:0] base, input logic [7:0] dbase);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) begin
        checkOutput("sweep_first_addr", {16'd0, mem_a}, 32'h0000);
        checkOutput("sweep_first_we", {31'd0, mem_we}, 32'd1);
      end
      if (i == 5) checkOutput("full_after_3", {31'd0, tape_full}, 32'd0);
      if (i == 6) begin
        checkOutput("full_after_4", {31'd0, tape_full}, 32'd1);
        checkOutput("ovf_before_5th", {31'd0, tape_ovf}, 32'd0);
      end
      if (i == 7) begin
        checkOutput("full_after_5", {31'd0, tape_full}, 32'd1);
        checkOutput("ovf_after_5th", {31'd0, tape_ovf}, 32'd1);
      end
      if (i >= 2 && i <= 6)
        applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, base + 16'(i - 2), dbase + 8'(i - 2));
      else
        idle();
    end
  endtask

  task automatic queueSweep();
    for (int a = 0; a < 65536; a++)
      pushExp(1'b1, 16'(a), FILL);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    tape_done_in = 1'b0;
    idle();
    repeat (3) tick();

    checkOutput("rst_mem_ce", {31'd0, mem_ce}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_mem_a", {16'd0, mem_a}, 32'h0000);
    checkOutput("rst_mem_di", {24'd0, mem_di}, 32'h00);
    checkOutput("rst_cpu_q", {24'd0, cpu_q}, {24'd0, FILL});
    checkOutput("rst_clr_busy", {31'd0, clr_busy}, 32'd1);
    checkOutput("rst_flags", {29'd0, tape_full, tape_ovf, tape_done_out}, 32'd0);

    // First sweep, aborted by reset partway through with an overflowed FIFO.
    queueSweep();
    reset = 1'b0;
    overflowPhase(16'h0600, 8'hB1);
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (mem_a == 16'h0800) break;
    end
    checkOutput("sweep1_reach_0800", {16'd0, mem_a}, 32'h0800);
    reset = 1'b1;
    tick();
    exp_q.delete();
    checkOutput("midrst_clr_busy", {31'd0, clr_busy}, 32'd1);
    checkOutput("midrst_mem_ce", {31'd0, mem_ce}, 32'd0);
    checkOutput("midrst_full", {31'd0, tape_full}, 32'd0);
    checkOutput("midrst_ovf", {31'd0, tape_ovf}, 32'd0);

    // Full sweep; only the first four queued tape writes may follow it.
    queueSweep();
    reset = 1'b0;
    overflowPhase(16'h0700, 8'hA1);
    for (int k = 0; k < 4; k++)
      pushExp(1'b1, 16'h0700 + 16'(k), 8'hA1 + 8'(k));
    for (int i = 9; i <= 65536; i++) begin
      tick();
      if (i == 65535) checkOutput("busy_at_65535", {31'd0, clr_busy}, 32'd1);
      if (i == 65536) begin
        checkOutput("busy_at_65536", {31'd0, clr_busy}, 32'd0);
        checkOutput("last_clear_addr", {16'd0, mem_a}, 32'hFFFF);
      end
    end
    repeat (5) tick();
    checkOutput("idle_after_drain", {31'd0, mem_ce}, 32'd0);
    checkOutput("queue_after_drain", exp_q.size(), 32'd0);
    checkOutput("ram_0702", {24'd0, ram[16'h0702]}, 32'hA3);
    checkOutput("ram_0704_untouched", {24'd0, ram[16'h0704]}, 32'hFF);

    // CPU write then read of 0x1234.
    applyStimulus(1'b1, 1'b1, 16'h1234, 8'h5A, 1'b0, 16'h0000, 8'h00);
    pushExp(1'b1, 16'h1234, 8'h5A);
    tick();
    checkOutput("cpu_wr_we", {31'd0, mem_we}, 32'd1);
    applyStimulus(1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 16'h0000, 8'h00);
    pushExp(1'b0, 16'h1234, 8'h00);
    tick();
    idle();
    tick();
    checkOutput("cpu_q_held", {24'd0, cpu_q}, 32'hFF);
    tick();
    checkOutput("cpu_q_rd_1234", {24'd0, cpu_q}, 32'h5A);

    // CPU holds a read of 0x0400 while three tape writes use its repeat slots.
    applyStimulus(1'b1, 1'b0, 16'h0400, 8'h00, 1'b1, 16'h0500, 8'h11);
    pushExp(1'b0, 16'h0400, 8'h00);
    pushExp(1'b1, 16'h0500, 8'h11);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0400, 8'h00, 1'b1, 16'h0501, 8'h22);
    pushExp(1'b1, 16'h0501, 8'h22);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0400, 8'h00, 1'b1, 16'h0502, 8'h33);
    pushExp(1'b1, 16'h0502, 8'h33);
    tick();
    idle();
    tape_done_in = 1'b1;
    checkOutput("cpu_q_rd_0400", {24'd0, cpu_q}, 32'hFF);
    tick();
    checkOutput("done_while_pending", {31'd0, tape_done_out}, 32'd0);
    tick();
    checkOutput("done_after_empty", {31'd0, tape_done_out}, 32'd1);
    checkOutput("idle_after_tape", {31'd0, mem_ce}, 32'd0);
    tape_done_in = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h0501, 8'h00, 1'b0, 16'h0000, 8'h00);
    pushExp(1'b0, 16'h0501, 8'h00);
    tick();
    idle();
    tick();
    tick();
    checkOutput("cpu_q_rd_0501", {24'd0, cpu_q}, 32'h22);
    checkOutput("done_dropped", {31'd0, tape_done_out}, 32'd0);

    // Two tape writes held back by fresh CPU reads while tape_done_in is high.
    applyStimulus(1'b1, 1'b0, 16'h1234, 8'h00, 1'b1, 16'h0600, 8'h44);
    pushExp(1'b0, 16'h1234, 8'h00);
    tick();
    tape_done_in = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'h0500, 8'h00, 1'b1, 16'h0601, 8'h55);
    pushExp(1'b0, 16'h0500, 8'h00);
    pushExp(1'b1, 16'h0600, 8'h44);
    pushExp(1'b1, 16'h0601, 8'h55);
    tick();
    idle();
    checkOutput("done_q2_f1", {31'd0, tape_done_out}, 32'd0);
    checkOutput("full_at_2", {31'd0, tape_full}, 32'd0);
    tick();
    checkOutput("done_q2_f2", {31'd0, tape_done_out}, 32'd0);
    checkOutput("cpu_q_rd_1234_b", {24'd0, cpu_q}, 32'h5A);
    tick();
    checkOutput("done_q2_f3", {31'd0, tape_done_out}, 32'd0);
    checkOutput("cpu_q_rd_0500", {24'd0, cpu_q}, 32'h11);
    tick();
    checkOutput("done_q2_f4", {31'd0, tape_done_out}, 32'd1);
    tape_done_in = 1'b0;

    repeat (3) tick();
    checkOutput("queue_final", exp_q.size(), 32'd0);
    checkOutput("ram_0601", {24'd0, ram[16'h0601]}, 32'h55);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
